if_fetch_buffer: RTL

- Fetch-stage consumer of the PC register. Captures instruction-SRAM read data that returns one cycle after the PC register issues an address.
- Pairs each returned word with its PC and stores the pair in a small FIFO.
- Presents the FIFO head to the ID stage with a valid/allow_in handshake.
- Drives if_allow_in back to the PC register, so fetch stalls only when the buffer could overflow. On a taken branch it discards all wrong-path instructions.

---
 rtl/if_fetch_buffer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: fetch-stage buffer between the PC register and ID.
// Each instruction-SRAM response arrives one cycle after its request. It is
// paired with its PC and queued in a small circular FIFO. The FIFO head is
// presented to ID with a valid/allow_in handshake.
// if_allow_in throttles the PC register so that no response can ever arrive
// while the buffer is full.
// A taken branch empties the buffer. It also drops the single response that
// was already in flight when the redirect happened.
// Optional build macro IF_ADEF_EN: tags misaligned fetch PCs with an adef flag
// and exposes that flag to ID.
module if_fetch_buffer #(
    parameter int BUF_DEPTH = 2,
    parameter int PC_W      = 32,
    parameter int INST_W    = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              resp_valid,
    input  logic [PC_W-1:0]   resp_pc,
    input  logic [INST_W-1:0] inst_sram_rdata,
    input  logic              br_flush,
    input  logic              id_allow_in,
    output logic              if_allow_in,
    output logic              if_to_id_valid,
    output logic [PC_W-1:0]   if_to_id_pc,
    output logic [INST_W-1:0] if_to_id_inst
`ifdef IF_ADEF_EN
    ,
    output logic              if_to_id_adef
`endif
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(BUF_DEPTH);

    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              drop_next_reg;
    logic              push;
    logic              pop;
    logic              not_empty;
    logic [CNT_W:0]    occupancy;
    logic [INST_W-1:0] wr_inst;

    logic [PC_W-1:0]   pc_mem   [BUF_DEPTH];
    logic [INST_W-1:0] inst_mem [BUF_DEPTH];

    assign not_empty = (count_reg != '0);

    // A response is dropped in the redirect cycle and in the cycle after it.
    // The second case covers a request that was issued before the redirect
    // reached the PC register.
    assign push = resetn & resp_valid & ~br_flush & ~drop_next_reg;
    assign pop  = not_empty & id_allow_in & ~br_flush;

    // Pops are ignored here on purpose. Counting the worst case (no pop)
    // guarantees that an accepted request's response always finds a free slot.
    assign occupancy   = {1'b0, count_reg} + {{CNT_W{1'b0}}, resp_valid};
    assign if_allow_in = resetn & (occupancy < DEPTH_LIM);

`ifdef IF_ADEF_EN
    logic adef_mem [BUF_DEPTH];
    logic wr_adef;

    assign wr_adef = (resp_pc[1:0] != 2'b00);
    assign wr_inst = wr_adef ? '0 : inst_sram_rdata;

    // Store the misalignment flag alongside each entry.
    always_ff @(posedge clk) begin
        if (push) begin
            adef_mem[wr_ptr_reg] <= wr_adef;
        end
    end

    // Expose the head flag only while the head entry is valid.
    always_comb begin
        if_to_id_adef = 1'b0;
        if (resetn && not_empty) begin
            if_to_id_adef = adef_mem[rd_ptr_reg];
        end
    end
`else
    assign wr_inst = inst_sram_rdata;
`endif

    // Entry storage: written only on an accepted push, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]   <= resp_pc;
            inst_mem[wr_ptr_reg] <= wr_inst;
        end
    end

    // Compute the next pointer and occupancy values. A flush overrides
    // push and pop.
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (br_flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_ONE;
                2'b01:   count_next = count_reg - CNT_ONE;
                default: count_next = count_reg;
            endcase
        end
    end

    // Control state register. Reset has priority over everything else.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            drop_next_reg <= 1'b0;
        end else begin
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_next;
            count_reg     <= count_next;
            drop_next_reg <= br_flush;
        end
    end

    // Head presentation: read combinationally from the array, with zeros
    // when the buffer is empty.
    always_comb begin
        if_to_id_valid = not_empty;
        if_to_id_pc    = '0;
        if_to_id_inst  = '0;
        if (not_empty) begin
            if_to_id_pc   = pc_mem[rd_ptr_reg];
            if_to_id_inst = inst_mem[rd_ptr_reg];
        end
    end

endmodule
